// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the two-master data-memory arbiter: owner encoding and burst default.
package dmem_arb_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_M0   = 2'd1,
    OWN_M1   = 2'd2
  } owner_e;

  localparam int MAX_BURST_DEF = 8;

  function automatic owner_e other_of(input owner_e o);
    return (o == OWN_M0) ? OWN_M1 : OWN_M0;
  endfunction

endpackage

// File: rtl/dmem_arbiter.sv
// Two-master arbiter for a single-port data memory; grant 1 cycle after req, owner holds while req stays high.
// Backpressure is the grant itself. DMEM_ARB_BURST_LIMIT_EN hands over after MAX_BURST transfers when the other master waits.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int MAX_BURST  = MAX_BURST_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_we,
  input  logic                  m1_we,
  input  logic [ADDR_WIDTH-1:0] m0_addr,
  input  logic [ADDR_WIDTH-1:0] m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wr_data,
  input  logic [DATA_WIDTH-1:0] mem_rd_data
);

  localparam int              CNT_W   = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_BURST);

  owner_e           owner_q, owner_d;
  owner_e           last_owner_q, last_owner_d;
  logic [CNT_W-1:0] burst_cnt_q, burst_cnt_d;

  logic                  own_req;
  logic                  own_we;
  logic                  oth_req;
  logic [ADDR_WIDTH-1:0] own_addr;
  logic [DATA_WIDTH-1:0] own_wdata;
  logic [CNT_W-1:0]      cnt_inc;

  assign m0_gnt = (owner_q == OWN_M0);
  assign m1_gnt = (owner_q == OWN_M1);

  // Owner-side mux; everything stays zero when nobody owns the memory.
  always_comb begin
    own_req   = 1'b0;
    own_we    = 1'b0;
    oth_req   = 1'b0;
    own_addr  = '0;
    own_wdata = '0;
    case (owner_q)
      OWN_M0: begin
        own_req   = m0_req;
        own_we    = m0_we;
        own_addr  = m0_addr;
        own_wdata = m0_wdata;
        oth_req   = m1_req;
      end
      OWN_M1: begin
        own_req   = m1_req;
        own_we    = m1_we;
        own_addr  = m1_addr;
        own_wdata = m1_wdata;
        oth_req   = m0_req;
      end
      default: ;
    endcase
  end

  assign mem_wr_en   = own_req && own_we && (m0_gnt || m1_gnt);
  assign mem_addr    = own_addr;
  assign mem_wr_data = own_wdata;
  assign m0_rdata    = mem_rd_data;
  assign m1_rdata    = mem_rd_data;

  assign cnt_inc = (burst_cnt_q == CNT_MAX) ? CNT_MAX : burst_cnt_q + 1'b1;

  always_comb begin
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    burst_cnt_d  = burst_cnt_q;
    case (owner_q)
      OWN_NONE: begin
        burst_cnt_d = '0;
        if (m0_req && m1_req) begin
          owner_d = other_of(last_owner_q);
        end else if (m0_req) begin
          owner_d = OWN_M0;
        end else if (m1_req) begin
          owner_d = OWN_M1;
        end
      end
      OWN_M0, OWN_M1: begin
        if (own_req) begin
          last_owner_d = owner_q;
          burst_cnt_d  = cnt_inc;
`ifdef DMEM_ARB_BURST_LIMIT_EN
          // Handover happens on the edge that completes the MAX_BURST-th transfer.
          if (oth_req && (cnt_inc == CNT_MAX)) begin
            owner_d     = other_of(owner_q);
            burst_cnt_d = '0;
          end
`endif
        end else begin
          // Idle granted slot: the owner released, so hand over or go idle.
          owner_d     = oth_req ? other_of(owner_q) : OWN_NONE;
          burst_cnt_d = '0;
        end
      end
      default: begin
        owner_d     = OWN_NONE;
        burst_cnt_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_q      <= OWN_NONE;
      last_owner_q <= OWN_M1;
      burst_cnt_q  <= '0;
    end else begin
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      burst_cnt_q  <= burst_cnt_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: per-cycle vector table, write scoreboard, and burst / reset corner sequences.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [31:0] m0_addr, m1_addr, m0_wdata, m1_wdata;
  logic        m0_gnt, m1_gnt, mem_wr_en;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wr_data, mem_rd_data;

  logic [31:0] mem [0:63];

  dmem_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wr_data(mem_wr_data),
    .mem_rd_data(mem_rd_data)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Word-addressed memory as the parent would place it: combinational read, synchronous write.
  assign mem_rd_data = mem[mem_addr[7:2]];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr[7:2]] = mem_wr_data;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] d;
  } wr_t;
  wr_t exp_q[$];

  always @(negedge clk) begin
    if (rst_n && mem_wr_en) begin
      chk("wr_expected", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        wr_t w;
        w = exp_q.pop_front();
        chk("wr_addr", 64'(mem_addr), 64'(w.a));
        chk("wr_data", 64'(mem_wr_data), 64'(w.d));
      end
    end
  end

  typedef struct {
    logic        r;
    logic        m0r, m0w;
    logic [31:0] m0a, m0d;
    logic        m1r, m1w;
    logic [31:0] m1a, m1d;
    logic        g0, g1, wr;
    logic [31:0] ea;
    logic        rd;
    logic [31:0] erd;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic m0r, input logic m0w,
                              input logic [31:0] m0a, input logic [31:0] m0d,
                              input logic m1r, input logic m1w,
                              input logic [31:0] m1a, input logic [31:0] m1d,
                              input logic g0, input logic g1, input logic wr,
                              input logic [31:0] ea, input logic rd, input logic [31:0] erd);
    vec_t v;
    v.r = r; v.m0r = m0r; v.m0w = m0w; v.m0a = m0a; v.m0d = m0d;
    v.m1r = m1r; v.m1w = m1w; v.m1a = m1a; v.m1d = m1d;
    v.g0 = g0; v.g1 = g1; v.wr = wr; v.ea = ea; v.rd = rd; v.erd = erd;
    return v;
  endfunction

  task automatic drive(input logic r, input logic m0r, input logic m0w,
                       input logic [31:0] m0a, input logic [31:0] m0d,
                       input logic m1r, input logic m1w,
                       input logic [31:0] m1a, input logic [31:0] m1d);
    rst_n = r; m0_req = m0r; m0_we = m0w; m0_addr = m0a; m0_wdata = m0d;
    m1_req = m1r; m1_we = m1w; m1_addr = m1a; m1_wdata = m1d;
  endtask

  task automatic apply(input int i, input vec_t v);
    @(posedge clk); #1;
    drive(v.r, v.m0r, v.m0w, v.m0a, v.m0d, v.m1r, v.m1w, v.m1a, v.m1d);
    if (v.wr) exp_q.push_back({v.ea, (v.g0 ? v.m0d : v.m1d)});
    @(negedge clk);
    chk($sformatf("v%0d_m0_gnt", i), 64'(m0_gnt), 64'(v.g0));
    chk($sformatf("v%0d_m1_gnt", i), 64'(m1_gnt), 64'(v.g1));
    chk($sformatf("v%0d_wr_en", i), 64'(mem_wr_en), 64'(v.wr));
    chk($sformatf("v%0d_addr", i), 64'(mem_addr), 64'(v.ea));
    if (!v.g0 && !v.g1) chk($sformatf("v%0d_wdata_zero", i), 64'(mem_wr_data), 64'd0);
    if (v.rd) chk($sformatf("v%0d_rdata", i), 64'(v.g0 ? m0_rdata : m1_rdata), 64'(v.erd));
  endtask

  vec_t vecs[22];
  int   cnt;
  bit   seen;

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    drive(1'b0, 1'b1, 1'b1, 32'h10, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0, 32'h0);

    //           r  m0r m0w m0a    m0d           m1r m1w m1a    m1d           g0 g1 wr addr   rd rdata
    vecs[0]  = mk(0, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[1]  = mk(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[2]  = mk(1, 1, 1, 32'h10, 32'hDEADBEEF, 0, 0, 32'h00, 32'h0,        1, 0, 1, 32'h10, 0, 32'h0);
    vecs[3]  = mk(1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h10, 1, 32'hDEADBEEF);
    vecs[4]  = mk(1, 0, 1, 32'h10, 32'h55555555, 0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h10, 0, 32'h0);
    vecs[5]  = mk(1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[6]  = mk(1, 1, 0, 32'h10, 32'h0,        0, 0, 32'h00, 32'h0,        1, 0, 0, 32'h10, 1, 32'hDEADBEEF);
    vecs[7]  = mk(1, 0, 0, 32'h10, 32'h0,        1, 1, 32'h14, 32'hCAFEF00D, 1, 0, 0, 32'h10, 0, 32'h0);
    vecs[8]  = mk(1, 0, 0, 32'h10, 32'h0,        1, 1, 32'h14, 32'hCAFEF00D, 0, 1, 1, 32'h14, 0, 32'h0);
    vecs[9]  = mk(1, 0, 0, 32'h10, 32'h0,        1, 0, 32'h14, 32'h0,        0, 1, 0, 32'h14, 1, 32'hCAFEF00D);
    vecs[10] = mk(1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h14, 32'h0,        0, 1, 0, 32'h14, 0, 32'h0);
    vecs[11] = mk(1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[12] = mk(0, 1, 1, 32'h18, 32'h11111111, 1, 0, 32'h14, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[13] = mk(1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[14] = mk(1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14, 32'h0,        1, 0, 0, 32'h10, 1, 32'hDEADBEEF);
    vecs[15] = mk(1, 0, 0, 32'h10, 32'h0,        1, 0, 32'h14, 32'h0,        1, 0, 0, 32'h10, 0, 32'h0);
    vecs[16] = mk(1, 0, 0, 32'h10, 32'h0,        0, 0, 32'h14, 32'h0,        0, 1, 0, 32'h14, 0, 32'h0);
    vecs[17] = mk(1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[18] = mk(1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);
    vecs[19] = mk(1, 1, 0, 32'h10, 32'h0,        1, 0, 32'h14, 32'h0,        0, 1, 0, 32'h14, 1, 32'hCAFEF00D);
    vecs[20] = mk(1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 1, 0, 32'h00, 0, 32'h0);
    vecs[21] = mk(1, 0, 0, 32'h00, 32'h0,        0, 0, 32'h00, 32'h0,        0, 0, 0, 32'h00, 0, 32'h0);

    @(negedge clk);
    chk("reset_m0_gnt", 64'(m0_gnt), 64'd0);
    chk("reset_wr_en", 64'(mem_wr_en), 64'd0);
    chk("reset_addr", 64'(mem_addr), 64'd0);
    chk("reset_wdata", 64'(mem_wr_data), 64'd0);

    for (int i = 0; i < 22; i++) apply(i, vecs[i]);

    // m0 holds a read burst while m1 waits from the first granted cycle.
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h0, 1'b0, 1'b0, 32'h44, 32'h0);
    @(negedge clk);
    chk("burst_start_idle", 64'(m0_gnt), 64'd0);
    cnt  = 0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk); #1;
      m1_req = 1'b1;
      @(negedge clk);
      if (m1_gnt) begin
        seen = 1'b1;
        break;
      end
      if (m0_gnt && m0_req) cnt++;
    end
`ifdef DMEM_ARB_BURST_LIMIT_EN
    chk("burst_m1_granted", 64'(seen), 64'd1);
    chk("burst_m0_transfers", 64'(cnt), 64'd8);
`else
    chk("lock_m1_not_granted", 64'(seen), 64'd0);
    chk("lock_m0_transfers", 64'(cnt), 64'd20);
    @(posedge clk); #1;
    m0_req = 1'b0;
    @(negedge clk);
    chk("lock_release_idle_m0", 64'(m0_gnt), 64'd1);
    chk("lock_release_idle_m1", 64'(m1_gnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lock_m1_after_release", 64'(m1_gnt), 64'd1);
`endif
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    // Reset pulse lands in the middle of a granted write cycle.
    #1;
    drive(1'b1, 1'b1, 1'b1, 32'h20, 32'h12345678, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    exp_q.push_back({32'h20, 32'h12345678});
    @(negedge clk);
    chk("rstw_gnt_before", 64'(m0_gnt), 64'd1);
    chk("rstw_wr_en_before", 64'(mem_wr_en), 64'd1);
    #1;
    rst_n = 1'b0;
    #1;
    chk("rstw_wr_en", 64'(mem_wr_en), 64'd0);
    chk("rstw_addr", 64'(mem_addr), 64'd0);
    chk("rstw_wdata", 64'(mem_wr_data), 64'd0);
    chk("rstw_gnt", 64'(m0_gnt), 64'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b1, 1'b0, 32'h20, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    chk("rstw_no_early_gnt", 64'(m0_gnt), 64'd0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("rstw_read_gnt", 64'(m0_gnt), 64'd1);
    chk("rstw_read_zero", 64'(m0_rdata), 64'd0);
    @(posedge clk); #1;
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(posedge clk);

    chk("wr_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter DATA_WIDTH, 32, data bus width.
REQ-002 SHALL have parameter ADDR_WIDTH, 32, byte-address width.
REQ-003 SHALL have parameter MAX_BURST, 8, max consecutive transfers per owner while the other requests.
REQ-004 SHALL have port clk  input  1  single clock; all state on posedge.
REQ-005 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have ports m0_req, m1_req  input  1  access request / valid.
REQ-007 SHALL have ports m0_we, m1_we  input  1  1 = write, 0 = read.
REQ-008 SHALL have ports m0_addr, m1_addr  input  ADDR_WIDTH  byte address.
REQ-009 SHALL have ports m0_wdata, m1_wdata  input  DATA_WIDTH  write data.
REQ-010 SHALL have ports m0_gnt, m1_gnt  output  1  master owns the memory this cycle.
REQ-011 SHALL have ports m0_rdata, m1_rdata  output  DATA_WIDTH  read data.
REQ-012 SHALL have ports mem_wr_en  output  1, mem_addr  output  ADDR_WIDTH, mem_wr_data  output  DATA_WIDTH, driving the word-addressed data memory (combinational read, synchronous write).
REQ-013 SHALL have port mem_rd_data  input  DATA_WIDTH  memory read data.

Function
REQ-014 SHALL keep owner register in {NONE, M0, M1}; mi_gnt = (owner==Mi), decoded from registers only.
REQ-015 SHALL count a transfer for master i in any cycle with mi_req && mi_gnt; gnt without req is an idle slot with no memory effect.
REQ-016 SHALL drive mem_addr/mem_wr_data from the owner's inputs and mem_wr_en = owner_we && owner_req && owner_gnt; when owner==NONE, all three are 0.
REQ-017 SHALL drive both mi_rdata = mem_rd_data combinationally; data is valid only in a read-transfer cycle of master i.
REQ-018 SHALL, from NONE, grant at the next edge the single requester, or, if both request, the master not in last_owner; latency from req rise to gnt = 1 cycle.
REQ-019 SHALL, while owner==Mi and mi_req=1, keep owner and increment burst_cnt per transfer.
REQ-020 SHALL, when owner==Mi samples mi_req=0 at an edge, move to the other master if it requests, else NONE; burst_cnt clears on every owner change.
REQ-021 SHALL record last_owner on every transfer; no transfer is ever lost, duplicated or split across owners.
REQ-022 SHALL size burst_cnt as $clog2(MAX_BURST+1) bits, saturating at MAX_BURST.

Reset
REQ-023 SHALL, on rst_n low (any time, including mid-burst or during a write cycle), immediately force owner=NONE, burst_cnt=0, last_owner=M1, both gnt=0, mem_wr_en=0, mem_addr=0, mem_wr_data=0.
REQ-024 SHALL grant no master before the first clk edge after rst_n deasserts.

Configuration
REQ-025 SHALL, with DMEM_ARB_BURST_LIMIT_EN defined, transfer ownership at the edge where burst_cnt reaches MAX_BURST and the other master requests (fairness).
REQ-026 SHALL, without DMEM_ARB_BURST_LIMIT_EN, let the owner keep the grant until it drops req (lock mode); burst_cnt is still maintained.

Structure
REQ-027 SHALL take owner encoding (NONE=2'd0, M0=2'd1, M1=2'd2) and MAX_BURST default from shared package dmem_arb_pkg.
REQ-028 SHALL be one flat module with no sub-module; the data memory is instantiated by the parent alongside it.

Verification
REQ-029 SHALL check: reset, m0_req=1 we=1 addr=0x10 wdata=0xDEADBEEF -> m0_gnt one cycle later, one write, then m0 read addr=0x10 returns 0xDEADBEEF.
REQ-030 SHALL check: from NONE both req rise together after reset -> M0 granted first; repeat after M0 done -> M1 granted first.
REQ-031 SHALL check with macro, MAX_BURST=8: m0 holds req, m1 requests -> exactly 8 m0 transfers, then m1_gnt next cycle.
REQ-032 SHALL check without macro: same stimulus -> m1 never granted until m0_req drops, then m1_gnt one cycle later.
REQ-033 SHALL check: rst_n pulsed low mid-write of 0x12345678 to addr 0x20 -> mem_wr_en low immediately, no write lands, addr 0x20 reads 0.
REQ-034 SHALL check: owner drops req -> one idle gnt cycle, mem_wr_en=0 during it, memory contents unchanged.
